// File: rtl/mano_mem_arbiter.sv
// rtl/mano_mem_arbiter.sv - two-port round-robin arbiter and access sequencer for Mano main memory
//
// Shares the single memory port between the CPU control unit and the program
// loader. A winner's command is latched in IDLE, then the sequence
// ACCESS -> RESP -> FIN performs exactly one memory read or write.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU command (held until done_cpu)
//   gnt_cpu, done_cpu, rdata_cpu     CPU grant, completion pulse, read data
//   ld_*, gnt_ld, done_ld, rdata_ld  same set for the program loader
//   mem_ar, mem_din                  memory address / write data
//   mem_we, mem_re                   one-cycle memory write / read strobes
//   mem_dout                         memory read data, valid cycle after mem_re
//   busy                             sequencer not in IDLE
module mano_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          gnt_cpu,
  output logic          done_cpu,
  output logic [DW-1:0] rdata_cpu,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          gnt_ld,
  output logic          done_ld,
  output logic [DW-1:0] rdata_ld,
  output logic [AW-1:0] mem_ar,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          last_ld;     // 1: loader was served last
  logic          win_ld;      // 1: loader owns the current transaction
  logic          lat_we;      // latched write enable of the winner
  logic          sel_ld;      // arbitration result in IDLE
  logic          any_req;
  logic [AW-1:0] ar_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] rdata_cpu_q;
  logic [DW-1:0] rdata_ld_q;

  assign any_req = cpu_req | ld_req;
  // Loader wins when it is the only requester, or on a tie when the CPU
  // was served last.
  assign sel_ld  = ld_req & (~cpu_req | ~last_ld);

  // The address/data registers are loaded only when a command is latched,
  // so they present the command throughout ACCESS and keep the last driven
  // values afterwards.
  assign mem_ar    = ar_q;
  assign mem_din   = din_q;
  assign rdata_cpu = rdata_cpu_q;
  assign rdata_ld  = rdata_ld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_ld     <= 1'b1;
      win_ld      <= 1'b0;
      lat_we      <= 1'b0;
      ar_q        <= '0;
      din_q       <= '0;
      rdata_cpu_q <= '0;
      rdata_ld_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && any_req) begin
        win_ld  <= sel_ld;
        last_ld <= sel_ld;
        lat_we  <= sel_ld ? ld_we    : cpu_we;
        ar_q    <= sel_ld ? ld_addr  : cpu_addr;
        din_q   <= sel_ld ? ld_wdata : cpu_wdata;
      end
      // Read data arrives the cycle after the read strobe; only the
      // winner's register is touched, and never on a write.
      if (state == S_RESP && !lat_we) begin
        if (win_ld) begin
          rdata_ld_q <= mem_dout;
        end else begin
          rdata_cpu_q <= mem_dout;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt_cpu    = 1'b0;
    gnt_ld     = 1'b0;
    done_cpu   = 1'b0;
    done_ld    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        gnt_cpu    = ~win_ld;
        gnt_ld     = win_ld;
        mem_we     = lat_we;
        mem_re     = ~lat_we;
        state_next = S_RESP;
      end
      S_RESP: begin
        gnt_cpu    = ~win_ld;
        gnt_ld     = win_ld;
        state_next = S_FIN;
      end
      S_FIN: begin
        gnt_cpu    = ~win_ld;
        gnt_ld     = win_ld;
        done_cpu   = ~win_ld;
        done_ld    = win_ld;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// tb/tb_mano_mem_arbiter.sv - directed self-checking bench for mano_mem_arbiter
module tb_mano_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        gnt_cpu, done_cpu;
  logic [15:0] rdata_cpu;
  logic        ld_req, ld_we;
  logic [11:0] ld_addr;
  logic [15:0] ld_wdata;
  logic        gnt_ld, done_ld;
  logic [15:0] rdata_ld;
  logic [11:0] mem_ar;
  logic [15:0] mem_din;
  logic        mem_we, mem_re;
  logic [15:0] mem_dout;
  logic        busy;

  int passed = 0;
  int total  = 0;

  mano_mem_arbiter #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .gnt_cpu(gnt_cpu), .done_cpu(done_cpu), .rdata_cpu(rdata_cpu),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .gnt_ld(gnt_ld), .done_ld(done_ld), .rdata_ld(rdata_ld),
    .mem_ar(mem_ar), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: word i starts as 16'hA000 | i, read data one cycle after mem_re.
  logic [15:0] mem [0:4095];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'hA000 | 16'(i);
      mem_init <= 1'b1;
      mem_dout <= 16'h0000;
    end else begin
      if (mem_we) mem[mem_ar] <= mem_din;
      if (mem_re) mem_dout <= mem[mem_ar];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int strobes;
    strobes = 0;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'h5A5A;
    ld_req = 1'b1;  ld_we = 1'b0;  ld_addr = 12'h456;  ld_wdata = 16'hA5A5;
    for (int i = 0; i < 2; i++) begin
      step();
      if (mem_we || mem_re) strobes++;
    end
    total++; if (strobes !== 0) $display("FAIL reset_strobes got %0d exp 0", strobes); else passed++;
    total++; if (gnt_cpu !== 1'b0) $display("FAIL reset_gnt_cpu got %b exp 0", gnt_cpu); else passed++;
    total++; if (gnt_ld !== 1'b0) $display("FAIL reset_gnt_ld got %b exp 0", gnt_ld); else passed++;
    total++; if (done_cpu !== 1'b0) $display("FAIL reset_done_cpu got %b exp 0", done_cpu); else passed++;
    total++; if (done_ld !== 1'b0) $display("FAIL reset_done_ld got %b exp 0", done_ld); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (mem_ar !== 12'h000) $display("FAIL reset_mem_ar got %h exp 000", mem_ar); else passed++;
    total++; if (mem_din !== 16'h0000) $display("FAIL reset_mem_din got %h exp 0000", mem_din); else passed++;
    total++; if (rdata_cpu !== 16'h0000) $display("FAIL reset_rdata_cpu got %h exp 0000", rdata_cpu); else passed++;
    total++; if (rdata_ld !== 16'h0000) $display("FAIL reset_rdata_ld got %h exp 0000", rdata_ld); else passed++;
    rst_n = 1'b1; cpu_req = 1'b0; ld_req = 1'b0;
    step();
  endtask

  task automatic test_ld_write_cpu_read();
    int we_cnt, done_at;
    logic [11:0] we_ar;
    logic [15:0] we_din, rd_cpu_at, rd_ld_at;
    we_cnt = 0; done_at = -1; we_ar = 12'hFFF; we_din = 16'hFFFF;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h000; ld_wdata = 16'h1111;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (mem_we) begin we_cnt++; we_ar = mem_ar; we_din = mem_din; end
      if (done_ld) begin done_at = i; ld_req = 1'b0; end
    end
    total++; if (we_cnt !== 1) $display("FAIL ldw_we_count got %0d exp 1", we_cnt); else passed++;
    total++; if (we_ar !== 12'h000) $display("FAIL ldw_mem_ar got %h exp 000", we_ar); else passed++;
    total++; if (we_din !== 16'h1111) $display("FAIL ldw_mem_din got %h exp 1111", we_din); else passed++;
    total++; if (done_at !== 3) $display("FAIL ldw_done_latency got %0d exp 3", done_at); else passed++;

    done_at = -1; rd_cpu_at = 16'hFFFF; rd_ld_at = 16'hFFFF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 16'h0BAD;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (done_cpu) begin
        done_at = i; rd_cpu_at = rdata_cpu; rd_ld_at = rdata_ld; cpu_req = 1'b0;
      end
    end
    total++; if (done_at !== 3) $display("FAIL cpur_done_latency got %0d exp 3", done_at); else passed++;
    total++; if (rd_cpu_at !== 16'h1111) $display("FAIL cpur_rdata_cpu got %h exp 1111", rd_cpu_at); else passed++;
    total++; if (rd_ld_at !== 16'h0000) $display("FAIL cpur_rdata_ld got %h exp 0000", rd_ld_at); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cpur_idle_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_tie_after_reset();
    int cpu_at, ld_at, overlap;
    logic [15:0] rd;
    cpu_at = -1; ld_at = -1; overlap = 0; rd = 16'hFFFF;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h003; cpu_wdata = 16'h0000;
    ld_req = 1'b1;  ld_we = 1'b1;  ld_addr = 12'h001;  ld_wdata = 16'h2222;
    for (int i = 1; i <= 8; i++) begin
      step();
      if ((mem_we && mem_re) || (gnt_cpu && gnt_ld) || (done_cpu && done_ld)) overlap++;
      if (done_cpu) begin cpu_at = i; rd = rdata_cpu; cpu_req = 1'b0; end
      if (done_ld) begin ld_at = i; ld_req = 1'b0; end
    end
    total++; if (cpu_at !== 3) $display("FAIL tie_done_cpu_at got %0d exp 3", cpu_at); else passed++;
    total++; if (ld_at !== 7) $display("FAIL tie_done_ld_at got %0d exp 7", ld_at); else passed++;
    total++; if (overlap !== 0) $display("FAIL tie_overlap got %0d exp 0", overlap); else passed++;
    total++; if (rd !== 16'hA003) $display("FAIL tie_rdata_cpu got %h exp A003", rd); else passed++;
    total++; if (mem[1] !== 16'h2222) $display("FAIL tie_mem_write got %h exp 2222", mem[1]); else passed++;
  endtask

  task automatic test_contention();
    int n;
    logic seq [0:7];
    n = 0;
    for (int k = 0; k < 8; k++) seq[k] = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h003;
    ld_req = 1'b1;  ld_we = 1'b1;  ld_addr = 12'h005; ld_wdata = 16'h5555;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (mem_we || mem_re) begin
        if (n < 8) seq[n] = gnt_ld;
        n++;
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    step();
    total++; if (n !== 6) $display("FAIL cont_count got %0d exp 6", n); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (seq[k] !== 1'(k % 2)) $display("FAIL cont_grant_%0d got ld=%b exp ld=%b", k, seq[k], 1'(k % 2));
      else passed++;
    end
  endtask

  task automatic test_dropped_request();
    int done_at;
    logic [15:0] rd;
    logic [11:0] ar_resp;
    done_at = -1; rd = 16'hFFFF; ar_resp = 12'hFFF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h001;
    step();
    cpu_req = 1'b0; cpu_addr = 12'h007; cpu_we = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      if (i == 2) ar_resp = mem_ar;
      if (done_cpu) begin done_at = i; rd = rdata_cpu; end
    end
    total++; if (ar_resp !== 12'h001) $display("FAIL drop_mem_ar_hold got %h exp 001", ar_resp); else passed++;
    total++; if (done_at !== 3) $display("FAIL drop_done_at got %0d exp 3", done_at); else passed++;
    total++; if (rd !== 16'h2222) $display("FAIL drop_rdata_cpu got %h exp 2222", rd); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL drop_idle_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_mid_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h003;
    step();
    step();
    total++; if (gnt_cpu !== 1'b1) $display("FAIL midrst_resp_gnt got %b exp 1", gnt_cpu); else passed++;
    rst_n = 1'b0;
    step();
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else passed++;
    total++; if (done_cpu !== 1'b0) $display("FAIL midrst_done_cpu got %b exp 0", done_cpu); else passed++;
    total++; if (rdata_cpu !== 16'h0000) $display("FAIL midrst_rdata_cpu got %h exp 0000", rdata_cpu); else passed++;
    rst_n = 1'b1;
    cpu_req = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h009; ld_wdata = 16'h9999;
    step();
    total++; if (done_cpu !== 1'b0) $display("FAIL midrst_no_late_done got %b exp 0", done_cpu); else passed++;
    total++; if (gnt_cpu !== 1'b1) $display("FAIL midrst_tie_gnt_cpu got %b exp 1", gnt_cpu); else passed++;
    total++; if (gnt_ld !== 1'b0) $display("FAIL midrst_tie_gnt_ld got %b exp 0", gnt_ld); else passed++;
    step();
    step();
    cpu_req = 1'b0; ld_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_ld_write_cpu_read();
    test_tie_after_reset();
    test_contention();
    test_dropped_request();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
